// File: rtl/mix_column_engine.sv
// AES MixColumns / InvMixColumns engine: latches one 128-bit state per transaction and
// transforms COLS_PER_CYCLE columns per cycle in place before presenting the result.
module mix_column_engine #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inv,
  input  logic         in_bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int NUM_STEPS = 4 / COLS_PER_CYCLE;
  localparam logic [1:0] LAST_STEP = 2'(NUM_STEPS - 1);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("mix_column_engine: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // Handshake: a transfer happens on any rising edge where valid && ready; the producer
  // holds its payload until then, and ready never depends combinationally on valid.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t        state;
  logic [1:0]    cnt;
  logic [127:0]  work;
  logic [127:0]  work_next;
  logic          inv_q;
  logic          byp_q;
  logic          out_valid_q;
  logic          accept;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Inverse = forward core applied after multiplying by {05,00,04,00} (rotated),
  // which lets both directions share one xtime-based forward network.
  function automatic logic [31:0] col_mix(input logic [31:0] c, input logic inv,
                                          input logic byp);
    logic [7:0] a0, a1, a2, a3, u, v;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    if (inv) begin
      u  = xtime(xtime(a0 ^ a2));
      v  = xtime(xtime(a1 ^ a3));
      a0 = a0 ^ u;
      a2 = a2 ^ u;
      a1 = a1 ^ v;
      a3 = a3 ^ v;
    end
    if (byp) begin
      return c;
    end
    return {xtime(a0 ^ a1) ^ a1 ^ a2 ^ a3,
            xtime(a1 ^ a2) ^ a2 ^ a3 ^ a0,
            xtime(a2 ^ a3) ^ a3 ^ a0 ^ a1,
            xtime(a3 ^ a0) ^ a0 ^ a1 ^ a2};
  endfunction

  always_comb begin
    int          col_idx;
    logic [31:0] col;
    work_next = work;
    col_idx   = 0;
    col       = '0;
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      col_idx = int'(cnt) * COLS_PER_CYCLE + k;
      for (int r = 0; r < 4; r++) begin
        col[31-8*r -: 8] = work[127-8*(4*r+col_idx) -: 8];
      end
      col = col_mix(col, inv_q, byp_q);
      for (int r = 0; r < 4; r++) begin
        work_next[127-8*(4*r+col_idx) -: 8] = col[31-8*r -: 8];
      end
    end
  end

  assign in_ready  = (state == S_IDLE) || ((state == S_HOLD) && out_ready);
  assign accept    = in_valid && in_ready;
  assign busy      = (state != S_IDLE);
  assign out_valid = out_valid_q;
  assign out_state = work;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= 2'd0;
      work        <= '0;
      inv_q       <= 1'b0;
      byp_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            work  <= in_state;
            inv_q <= in_inv;
            byp_q <= in_bypass;
            cnt   <= 2'd0;
            state <= S_CALC;
          end
        end
        S_CALC: begin
          work <= work_next;
          if (cnt == LAST_STEP) begin
            cnt         <= 2'd0;
            state       <= S_HOLD;
            out_valid_q <= 1'b1;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            // Retiring and accepting share this edge so back-to-back states lose no cycle.
            if (in_valid) begin
              work  <= in_state;
              inv_q <= in_inv;
              byp_q <= in_bypass;
              cnt   <= 2'd0;
              state <= S_CALC;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mix_column_engine.sv
// Bench for mix_column_engine: three instances (1, 2 and 4 columns per cycle) driven one at
// a time, with a GF(2^8) product model feeding an expected-result queue.
module tb_mix_column_engine;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [127:0] in_state  [3];
  logic         in_inv    [3];
  logic         in_bypass [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] out_state [3];
  logic         busy      [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mix_column_engine #(.COLS_PER_CYCLE(1 << g)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_state  (in_state[g]),
      .in_inv    (in_inv[g]),
      .in_bypass (in_bypass[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_state (out_state[g]),
      .busy      (busy[g])
    );
  end

  // Clock / reset
  always #5 clk = ~clk;

  localparam logic [127:0] FIPS_IN  = 128'hdbf201c6_130a01c6_532201c6_455c01c6;
  localparam logic [127:0] FIPS_OUT = 128'h8e9f01c6_4ddc01c6_a15801c6_bc9d01c6;
  localparam logic [127:0] BYP_IN   = 128'h00112233_44556677_8899aabb_ccddeeff;

  logic [127:0] exp_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  logic         last_acc;

  // Reference model: direct GF(2^8) products, mod 0x11B
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_model(input logic [127:0] s, input logic inv,
                                             input logic byp);
    logic [7:0]   coef [4];
    logic [7:0]   acc;
    logic [127:0] res;
    if (byp) return s;
    if (inv) begin
      coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    end else begin
      coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    end
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) begin
          acc = acc ^ gmul(coef[j], s[127-8*(4*((r+j)%4)+c) -: 8]);
        end
        res[127-8*(4*r+c) -: 8] = acc;
      end
    end
    return res;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver: one clock for instance d; scoreboard pops on retire, pushes on accept.
  task automatic tick(input int d);
    logic         acc, ret;
    logic [127:0] o;
    #1;
    acc = in_valid[d] && in_ready[d] && !rst;
    ret = out_valid[d] && out_ready[d] && !rst;
    o   = out_state[d];
    if (ret) begin
      check("sb_nonempty", 128'(exp_q.size() != 0), 128'd1);
      if (exp_q.size() != 0) check("sb_data", o, exp_q.pop_front());
    end
    if (acc) exp_q.push_back(ref_model(in_state[d], in_inv[d], in_bypass[d]));
    last_acc = acc;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int d, output int n);
    n = 0;
    while (!out_valid[d] && n < 20) begin
      tick(d);
      n++;
    end
  endtask

  task automatic xfer(input int d, input logic [127:0] st, input logic inv, input logic byp,
                      input logic [127:0] exp, output logic [127:0] got);
    int n;
    in_valid[d]  = 1'b1;
    in_state[d]  = st;
    in_inv[d]    = inv;
    in_bypass[d] = byp;
    out_ready[d] = 1'b1;
    tick(d);
    check("accept", 128'(last_acc), 128'd1);
    in_valid[d]  = 1'b0;
    in_state[d]  = {$urandom(), $urandom(), $urandom(), $urandom()};
    in_inv[d]    = ~inv;
    in_bypass[d] = ~byp;
    wait_valid(d, n);
    check("latency", 128'(n), 128'(4 >> d));
    check("result", out_state[d], exp);
    got = out_state[d];
    tick(d);
    check("idle_after_retire", 128'({out_valid[d], busy[d], in_ready[d]}), 128'b001);
  endtask

  initial begin
    logic [127:0] got, got2, st_a, st_b, st;
    int           n, sent, cyc, n_rand;
    logic         stale;

    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b0; in_state[i] = '0; in_inv[i] = 1'b0;
      in_bypass[i] = 1'b0; out_ready[i] = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int d = 0; d < 3; d++) begin
      // Reset state
      check("rst_out_valid", 128'(out_valid[d]), 128'd0);
      check("rst_in_ready", 128'(in_ready[d]), 128'd1);
      check("rst_busy", 128'(busy[d]), 128'd0);
      check("rst_out_state", out_state[d], 128'd0);

      // Known-answer vectors and bypass
      xfer(d, FIPS_IN, 1'b0, 1'b0, FIPS_OUT, got);
      xfer(d, got, 1'b1, 1'b0, FIPS_IN, got2);
      xfer(d, BYP_IN, 1'b1, 1'b1, BYP_IN, got);

      // Backpressure with a second transaction pending
      st_a = {$urandom(), $urandom(), $urandom(), $urandom()};
      st_b = {$urandom(), $urandom(), $urandom(), $urandom()};
      in_valid[d] = 1'b1; in_state[d] = st_a; in_inv[d] = 1'b0; in_bypass[d] = 1'b0;
      out_ready[d] = 1'b0;
      tick(d);
      in_state[d] = st_b; in_inv[d] = 1'b1;
      wait_valid(d, n);
      check("bp_latency", 128'(n), 128'(4 >> d));
      for (int k = 0; k < 5; k++) begin
        check("bp_stable", out_state[d], ref_model(st_a, 1'b0, 1'b0));
        check("bp_in_ready", 128'({in_ready[d], out_valid[d]}), 128'b01);
        tick(d);
      end
      out_ready[d] = 1'b1;
      tick(d);
      check("b2b_accept", 128'(last_acc), 128'd1);
      in_valid[d] = 1'b0;
      wait_valid(d, n);
      check("b2b_latency", 128'(n), 128'(4 >> d));
      check("b2b_result", out_state[d], ref_model(st_b, 1'b1, 1'b0));
      tick(d);
      check("b2b_drained", 128'(exp_q.size()), 128'd0);

      // Reset while in CALC
      in_valid[d] = 1'b1; in_state[d] = FIPS_IN; in_inv[d] = 1'b0; in_bypass[d] = 1'b0;
      out_ready[d] = 1'b0;
      tick(d);
      in_valid[d] = 1'b0;
      if (d != 2) tick(d);
      check("pre_rst_calc", 128'({busy[d], out_valid[d]}), 128'b10);
      rst = 1'b1;
      tick(d);
      rst = 1'b0;
      exp_q.delete();
      check("mid_rst_out_valid", 128'(out_valid[d]), 128'd0);
      check("mid_rst_in_ready", 128'(in_ready[d]), 128'd1);
      check("mid_rst_busy", 128'(busy[d]), 128'd0);
      check("mid_rst_out_state", out_state[d], 128'd0);
      out_ready[d] = 1'b1;
      stale = 1'b0;
      for (int k = 0; k < 8; k++) begin
        stale = stale | out_valid[d];
        tick(d);
      end
      check("no_stale_result", 128'(stale), 128'd0);

      // Forward then inverse round trips
      for (int k = 0; k < 8; k++) begin
        st = {$urandom(), $urandom(), $urandom(), $urandom()};
        xfer(d, st, 1'b0, 1'b0, ref_model(st, 1'b0, 1'b0), got);
        xfer(d, got, 1'b1, 1'b0, st, got2);
      end

      // Random stream with random modes and random out_ready
      n_rand = (d == 0) ? 1000 : 300;
      sent = 0;
      cyc  = 0;
      in_valid[d] = 1'b0;
      while ((sent < n_rand || exp_q.size() != 0) && cyc < n_rand * 20) begin
        if (!in_valid[d] && sent < n_rand && $urandom_range(0, 3) != 0) begin
          in_valid[d]  = 1'b1;
          in_state[d]  = {$urandom(), $urandom(), $urandom(), $urandom()};
          in_inv[d]    = 1'($urandom_range(0, 1));
          in_bypass[d] = ($urandom_range(0, 7) == 0);
        end
        out_ready[d] = ($urandom_range(0, 3) != 0);
        tick(d);
        cyc++;
        if (last_acc) begin
          sent++;
          in_valid[d] = 1'b0;
        end
      end
      check("rand_all_sent", 128'(sent), 128'(n_rand));
      check("rand_drained", 128'(exp_q.size()), 128'd0);
      in_valid[d] = 1'b0;
      out_ready[d] = 1'b0;
      tick(d);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mix_column_engine.md
Name: mix_column_engine

Overview:
- Sequential AES MixColumns / InvMixColumns engine. Processes COLS_PER_CYCLE state columns per clock.
- Mode is selected per transaction (forward, inverse or bypass). Uses valid/ready handshakes on both sides.
- Sits between the shift-rows and add-round-key stages of the round datapath. Serves both encrypt and decrypt rounds, and lets the area/throughput trade-off be chosen at elaboration.

Parameters:
- COLS_PER_CYCLE, 1, columns transformed per CALC cycle. Legal values are 1, 2 and 4; any other value is an elaboration error.
- NUM_STEPS, 4/COLS_PER_CYCLE, derived (localparam): number of CALC cycles per transaction.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  engine can accept a transaction.
- in_state  in  128  input state, row-major: s[r][c] = in_state[127-8*(4r+c) -: 8].
- in_inv  in  1  0 = forward MixColumns; 1 = InvMixColumns.
- in_bypass  in  1  1 = pass state unchanged; overrides in_inv.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_state  out  128  result, same row-major packing as in_state.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset and handshake
  - Reset is synchronous, active-high, one clock. On reset: FSM=IDLE, column counter=0, out_valid=0, in_ready=1, busy=0, out_state=0.
  - Reset has priority over all events. A transaction in CALC or HOLD is discarded with no output.
  - Accept occurs when in_valid && in_ready at a rising edge. At accept, latch in_state, in_inv and in_bypass; later changes on the in_* ports are ignored.
- FSM states
  - IDLE: in_ready=1. On accept go to CALC, counter=0.
  - CALC: in_ready=0, busy=1.
    - Each cycle, transform columns counter*COLS_PER_CYCLE .. +COLS_PER_CYCLE-1 in place in the working register.
    - Counter increments by 1 per cycle. When counter==NUM_STEPS-1, go to HOLD and assert out_valid on the next cycle.
  - HOLD: out_valid=1 and out_state is stable.
    - If out_ready=0, stay.
    - If out_ready=1 and in_valid=0, go to IDLE with out_valid=0 next cycle.
    - Back-to-back: in HOLD, in_ready = out_ready. If out_ready && in_valid, the result retires and the new transaction is accepted in the same cycle; go directly to CALC.
- Latency and throughput
  - Latency from accept edge to out_valid high is NUM_STEPS cycles: 4/2/1 for COLS_PER_CYCLE = 1/2/4.
  - Sustained throughput is one state per NUM_STEPS+1 cycles when out_ready is held high.
  - Bypass uses the same latency, so latency is constant for every mode.
- Arithmetic (GF(2^8), reduction polynomial 0x11B)
  - Forward, per column c: s'[r][c] = 02*s[r][c] ^ 03*s[r+1][c] ^ s[r+2][c] ^ s[r+3][c], row indices mod 4.
  - Inverse coefficient row r is a rotation of {0e,0b,0d,09}: s'[r][c] = 0e*s[r] ^ 0b*s[r+1] ^ 0d*s[r+2] ^ 09*s[r+3].
  - Any implementation is allowed (xtime chains, shared forward core + preprocess), provided the result is bit-exact with the direct product.
  - Columns not yet processed retain their input values until their step.
- Other rules
  - out_state is driven from the working register. It may change while out_valid=0; it is stable whenever out_valid=1.
  - No combinational path from in_valid to in_ready. in_ready in HOLD depends only on out_ready.
  - Arbitrary out_ready stalls must not corrupt or duplicate results.

Test Plan:
- FIPS-197 forward, COLS_PER_CYCLE=1.
  - Stimulus: in_state=128'hdbf201c6_130a01c6_532201c6_455c01c6, in_inv=0.
  - Required: out_state=128'h8e9f01c6_4ddc01c6_a15801c6_bc9d01c6, with out_valid exactly 4 cycles after accept.
- Inverse of the previous result, in_inv=1.
  - Required: returns 128'hdbf201c6_130a01c6_532201c6_455c01c6. Repeat for COLS_PER_CYCLE=2 (latency 2) and 4 (latency 1).
- Bypass: in_bypass=1, in_inv=1, in_state=128'h00112233_44556677_8899aabb_ccddeeff.
  - Required: identical out_state after NUM_STEPS cycles.
- Backpressure and back-to-back.
  - Stimulus: hold out_ready=0 for 5 cycles in HOLD, with a second transaction pending on in_valid.
  - Required: out_state stable and in_ready=0 during the stall. On out_ready=1 the first result retires and the second is accepted in the same cycle; the second result is correct.
- Reset mid-CALC: assert rst in CALC step 1.
  - Required: next cycle IDLE, out_valid=0, in_ready=1, busy=0, out_state=0. No stale result ever appears.
- Random self-check: 1000 random states with random modes and random out_ready.
  - Required: every output matches the reference model, and forward-then-inverse round trips to the original state.
